// File: rtl/s2b_pkg.sv
// Shared constants and width helpers for the small-to-big stream packer.
// The optional statistics counters are enabled with S2B_PACKER_STATS_EN.
package s2b_pkg;

  localparam int STATS_W = 16;
  localparam int DEF_DWI = 4;
  localparam int DEF_DWO = 16;
  localparam int DEF_R   = DEF_DWO / DEF_DWI;

  function automatic int calc_r(input int dwi, input int dwo);
    return dwo / dwi;
  endfunction

  // A single-symbol word still needs a 1-bit counter to keep the logic regular.
  function automatic int cnt_width(input int r);
    return (r <= 1) ? 1 : $clog2(r);
  endfunction

  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/s2b_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; a push into a full buffer with no
// simultaneous pop is refused and reported on drop.
module s2b_sync_fifo
  import s2b_pkg::*;
#(
  parameter int DW    = 16,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic          full,
  output logic          empty,
  output logic          drop
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic          push_ok;
  logic          pop_ok;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop_ok   = pop && !empty;
    // A pop in the same cycle frees the slot the push needs.
    push_ok  = push && (!full || pop_ok);
    drop     = push && !push_ok;
    wr_ptr_d = wr_ptr_q + PW'(push_ok);
    rd_ptr_d = rd_ptr_q + PW'(pop_ok);
    head     = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/s2b_packer.sv
// Small-to-big packer: assembles DWI-bit symbols into DWO-bit words and queues
// them in an output FIFO. Define S2B_PACKER_STATS_EN for word/drop counters.
module s2b_packer
  import s2b_pkg::*;
#(
  parameter int DWI       = 4,
  parameter int DWO       = 16,
  parameter int DEPTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic               dout_clk,
  input  logic               rstn,
  input  logic [DWI-1:0]     din,
  input  logic               din_en,
  input  logic               din_sof,
  output logic [DWO-1:0]     dout,
  output logic               dout_en,
  input  logic               dout_rdy,
  output logic               full,
  output logic               overflow,
  output logic               align_err,
  input  logic               clr_err
`ifdef S2B_PACKER_STATS_EN
  ,
  output logic [STATS_W-1:0] word_cnt,
  output logic [STATS_W-1:0] drop_cnt
`endif
);

  localparam int R  = calc_r(DWI, DWO);
  localparam int CW = cnt_width(R);

  // Output handshake: a word transfers on any edge where dout_en && dout_rdy;
  // dout/dout_en hold steady while dout_rdy is low.

  logic [DWO-1:0] acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           overflow_q, overflow_d;
  logic           align_err_q, align_err_d;

  logic           realign;
  logic [CW-1:0]  slot;
  logic [DWO-1:0] word;
  logic           complete;
  logic           fifo_empty;
  logic           fifo_drop;
  logic           pop;

  always_comb begin
    realign = din_en && din_sof && (cnt_q != '0);
    slot    = realign ? '0 : cnt_q;
    word    = realign ? '0 : acc_q;
    for (int i = 0; i < R; i++) begin
      if (slot == CW'(i)) begin
        word[((MSB_FIRST != 0) ? (R - 1 - i) : i) * DWI +: DWI] = din;
      end
    end
    complete = din_en && (slot == CW'(R - 1));

    acc_d = acc_q;
    cnt_d = cnt_q;
    if (din_en) begin
      if (complete) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = word;
        cnt_d = slot + CW'(1);
      end
    end

    // A new error event outranks a simultaneous clear.
    align_err_d = realign   ? 1'b1 : (clr_err ? 1'b0 : align_err_q);
    overflow_d  = fifo_drop ? 1'b1 : (clr_err ? 1'b0 : overflow_q);

    dout_en   = !fifo_empty;
    pop       = dout_en && dout_rdy;
    overflow  = overflow_q;
    align_err = align_err_q;
  end

  always_ff @(posedge dout_clk or negedge rstn) begin
    if (!rstn) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      overflow_q  <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      overflow_q  <= overflow_d;
      align_err_q <= align_err_d;
    end
  end

  s2b_sync_fifo #(
    .DW    (DWO),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (dout_clk),
    .rstn      (rstn),
    .push      (complete),
    .push_data (word),
    .pop       (pop),
    .head      (dout),
    .full      (full),
    .empty     (fifo_empty),
    .drop      (fifo_drop)
  );

`ifdef S2B_PACKER_STATS_EN
  logic [STATS_W-1:0] word_cnt_q, word_cnt_d;
  logic [STATS_W-1:0] drop_cnt_q, drop_cnt_d;
  logic               pushed;

  always_comb begin
    pushed     = complete && !fifo_drop;
    word_cnt_d = clr_err ? STATS_W'(pushed)    : word_cnt_q + STATS_W'(pushed);
    drop_cnt_d = clr_err ? STATS_W'(fifo_drop) : drop_cnt_q + STATS_W'(fifo_drop);
    word_cnt   = word_cnt_q;
    drop_cnt   = drop_cnt_q;
  end

  always_ff @(posedge dout_clk or negedge rstn) begin
    if (!rstn) begin
      word_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      word_cnt_q <= word_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end
`endif

endmodule
